// File: rtl/vec_pkg.sv
// Shared constants and state type for the vector memory stage.
// Lane slicing matches the vector ALU lane layout.
package vec_pkg;

    localparam int VEC_WIDTH  = 128;
    localparam int LANE_BITS  = 8;
    localparam int LANES      = VEC_WIDTH / LANE_BITS;
    localparam int MEM_ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STORE = 2'd1,
        LOAD  = 2'd2,
        DONE  = 2'd3
    } vmem_state_t;

endpackage

// File: rtl/vec_mem_unit.sv
// Multi-cycle vector load/store stage: serializes a vector to byte memory
// one lane per cycle, or gathers consecutive bytes into a vector.
module vec_mem_unit
    import vec_pkg::*;
#(
    parameter int WIDTH_V    = VEC_WIDTH,
    parameter int BITS_INDEX = LANE_BITS,
    parameter int ADDR_W     = MEM_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  is_store,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [WIDTH_V-1:0]    store_data,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH_V-1:0]    load_data,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [BITS_INDEX-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [BITS_INDEX-1:0] mem_rdata
);

    localparam int NLANES = WIDTH_V / BITS_INDEX;
    localparam int CNT_W  = $clog2(NLANES + 1);

    vmem_state_t          state;
    vmem_state_t          next_state;
    logic [CNT_W-1:0]     k;
    logic [ADDR_W-1:0]    base_q;
    logic [WIDTH_V-1:0]   data_q;
    logic [WIDTH_V-1:0]   shadow;
    logic [WIDTH_V-1:0]   shadow_next;
    logic [WIDTH_V-1:0]   load_q;
    logic [CNT_W-1:0]     lane_off;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = is_store ? STORE : LOAD;
            STORE:   if (k == CNT_W'(NLANES - 1)) next_state = DONE;
            LOAD:    if (k == CNT_W'(NLANES)) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Read data lags the address by one cycle, so cycle k fills lane k-1.
    always_comb begin
        shadow_next = shadow;
        for (int i = 0; i < NLANES; i++) begin
            if (k == CNT_W'(i + 1)) begin
                shadow_next[i*BITS_INDEX +: BITS_INDEX] = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k      <= '0;
            base_q <= '0;
            data_q <= '0;
            shadow <= '0;
            load_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q <= base_addr;
                        data_q <= store_data;
                        k      <= '0;
                    end
                end
                STORE: k <= k + CNT_W'(1);
                LOAD: begin
                    k      <= k + CNT_W'(1);
                    shadow <= shadow_next;
                    if (k == CNT_W'(NLANES)) begin
                        load_q <= shadow_next;
                    end
                end
                default: ;
            endcase
        end
    end

    // The final LOAD cycle only collects data; hold the last lane address.
    assign lane_off = (k == CNT_W'(NLANES)) ? CNT_W'(NLANES - 1) : k;

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            STORE: begin
                busy     = 1'b1;
                mem_we   = 1'b1;
                mem_addr = base_q + ADDR_W'(k);
                for (int i = 0; i < NLANES; i++) begin
                    if (k == CNT_W'(i)) begin
                        mem_wdata = data_q[i*BITS_INDEX +: BITS_INDEX];
                    end
                end
            end
            LOAD: begin
                busy     = 1'b1;
                mem_addr = base_q + ADDR_W'(lane_off);
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign load_data = load_q;

endmodule

// File: tb/tb_vec_mem_unit.sv
// Directed bench for vec_mem_unit with a byte-wide synchronous-read memory model.
module tb_vec_mem_unit;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         is_store;
    logic [15:0]  base_addr;
    logic [127:0] store_data;
    logic         busy;
    logic         done;
    logic [127:0] load_data;
    logic [15:0]  mem_addr;
    logic [7:0]   mem_wdata;
    logic         mem_we;
    logic [7:0]   mem_rdata;

    logic [7:0]   mem [0:65535];
    logic         pre_we;
    logic [15:0]  pre_addr;
    logic [7:0]   pre_data;
    int           we_cnt = 0;

    int n_vec = 0;
    int n_err = 0;

    vec_mem_unit dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .is_store   (is_store),
        .base_addr  (base_addr),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .load_data  (load_data),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
        if (mem_we) we_cnt <= we_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [15:0] base, input logic [7:0] first);
        for (int i = 0; i < 16; i++) begin
            pre_we   = 1'b1;
            pre_addr = base + 16'(i);
            pre_data = first + 8'(i);
            tick();
        end
        pre_we = 1'b0;
    endtask

    // Returns in cycle 1 of the operation.
    task automatic start_op(input logic st, input logic [15:0] base, input logic [127:0] data);
        start      = 1'b1;
        is_store   = st;
        base_addr  = base;
        store_data = data;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int c = 1;
        while (done !== 1'b1 && c < 40) begin
            tick();
            c++;
        end
        check(tag, 128'(c), 128'(exp_lat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] d1, d3, d4, exp_a, exp_5;
        int wc;

        for (int i = 0; i < 16; i++) begin
            d1[i*8 +: 8]    = 8'(i);
            d4[i*8 +: 8]    = 8'hC0 + 8'(i);
            exp_a[i*8 +: 8] = 8'hA0 + 8'(i);
            exp_5[i*8 +: 8] = 8'h50 + 8'(i);
            d3[i*8 +: 8]    = 8'h40 + 8'(i);
        end
        d3[7:0]   = 8'h11;
        d3[15:8]  = 8'h22;
        d3[23:16] = 8'h33;

        rst = 1'b1; start = 1'b0; is_store = 1'b0; base_addr = '0; store_data = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        repeat (3) tick();
        check("rst busy", 128'(busy), 128'(0));
        check("rst done", 128'(done), 128'(0));
        check("rst mem_we", 128'(mem_we), 128'(0));
        check("rst mem_addr", 128'(mem_addr), 128'(0));
        check("rst mem_wdata", 128'(mem_wdata), 128'(0));
        check("rst load_data", load_data, 128'(0));
        rst = 1'b0;
        tick();

        // 1: store, lane i = i, at 0x0010
        wc = we_cnt;
        start_op(1'b1, 16'h0010, d1);
        for (int c = 1; c <= 17; c++) begin
            if (c > 1) tick();
            check($sformatf("st busy c%0d", c), 128'(busy), 128'(c <= 16));
            check($sformatf("st done c%0d", c), 128'(done), 128'(c == 17));
            check($sformatf("st we c%0d", c), 128'(mem_we), 128'(c <= 16));
            if (c <= 16) begin
                check($sformatf("st addr c%0d", c), 128'(mem_addr), 128'(16'h0010 + 16'(c - 1)));
                check($sformatf("st wdata c%0d", c), 128'(mem_wdata), 128'(c - 1));
            end
        end
        tick();
        check("st idle busy", 128'(busy), 128'(0));
        check("st idle done", 128'(done), 128'(0));
        check("st idle addr", 128'(mem_addr), 128'(0));
        check("st write count", 128'(we_cnt - wc), 128'(16));
        for (int i = 0; i < 16; i++)
            check($sformatf("st mem %0d", i), 128'(mem[16'h0010 + 16'(i)]), 128'(i));
        check("st load_data kept", load_data, 128'(0));

        // 2: load from 0x0020, mem = A0+i
        preload(16'h0020, 8'hA0);
        wc = we_cnt;
        start_op(1'b0, 16'h0020, 128'(0));
        for (int c = 1; c <= 18; c++) begin
            if (c > 1) tick();
            check($sformatf("ld we c%0d", c), 128'(mem_we), 128'(0));
            check($sformatf("ld busy c%0d", c), 128'(busy), 128'(c <= 17));
            check($sformatf("ld done c%0d", c), 128'(done), 128'(c == 18));
            if (c <= 16) check($sformatf("ld addr c%0d", c), 128'(mem_addr), 128'(16'h0020 + 16'(c - 1)));
            if (c == 17) check("ld addr hold", 128'(mem_addr), 128'(16'h002F));
            check($sformatf("ld data c%0d", c), load_data, (c == 18) ? exp_a : 128'(0));
        end
        check("ld no writes", 128'(we_cnt - wc), 128'(0));
        tick();

        // 3: address wrap
        start_op(1'b1, 16'hFFFE, d3);
        wait_done("wrap st latency", 17);
        tick();
        check("wrap mem FFFE", 128'(mem[16'hFFFE]), 128'(8'h11));
        check("wrap mem FFFF", 128'(mem[16'hFFFF]), 128'(8'h22));
        check("wrap mem 0000", 128'(mem[16'h0000]), 128'(8'h33));
        start_op(1'b0, 16'hFFFE, 128'(0));
        wait_done("wrap ld latency", 18);
        check("wrap ld data", load_data, d3);
        tick();

        // 4: start re-pulsed during store and in DONE
        wc = we_cnt;
        start_op(1'b1, 16'h0100, d4);
        repeat (4) tick();
        start = 1'b1; is_store = 1'b0; base_addr = 16'h0500; store_data = '1;
        tick();
        start = 1'b0;
        repeat (11) tick();
        check("ign done c17", 128'(done), 128'(1));
        start = 1'b1; is_store = 1'b1; base_addr = 16'h0600;
        tick();
        start = 1'b0;
        check("ign busy c18", 128'(busy), 128'(0));
        check("ign we c18", 128'(mem_we), 128'(0));
        tick();
        check("ign busy c19", 128'(busy), 128'(0));
        check("ign write count", 128'(we_cnt - wc), 128'(16));
        check("ign mem last", 128'(mem[16'h010F]), 128'(8'hCF));
        check("ign load_data kept", load_data, d3);

        // 5: reset in cycle 8 of a load
        start_op(1'b0, 16'h0020, 128'(0));
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy", 128'(busy), 128'(0));
        check("abort done", 128'(done), 128'(0));
        check("abort we", 128'(mem_we), 128'(0));
        check("abort addr", 128'(mem_addr), 128'(0));
        check("abort load_data", load_data, 128'(0));
        tick();
        check("abort no done", 128'(done), 128'(0));
        preload(16'h0300, 8'h50);
        start_op(1'b0, 16'h0020, 128'(0));
        wait_done("fresh ld latency", 18);
        check("fresh ld data", load_data, exp_a);

        // 6: back-to-back start on the first IDLE cycle
        tick();
        check("b2b idle busy", 128'(busy), 128'(0));
        start_op(1'b0, 16'h0300, 128'(0));
        check("b2b busy c1", 128'(busy), 128'(1));
        check("b2b hold c1", load_data, exp_a);
        repeat (16) tick();
        check("b2b hold c17", load_data, exp_a);
        check("b2b done c17", 128'(done), 128'(0));
        tick();
        check("b2b done c18", 128'(done), 128'(1));
        check("b2b data c18", load_data, exp_5);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
